// File: rtl/stim_pkg.sv
// ---------------------------------------------------------------------------
// stim_pkg
//   Shared definitions for the stimulus sequencer slice: sequencer state
//   encoding, LFSR geometry and taps, MISR polynomial, and the latency of
//   the downstream stage whose responses are being compacted.
// ---------------------------------------------------------------------------
package stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // x^7 + x^6 + 1 : feedback is the XOR of the two most significant bits.
  localparam int LFSR_W      = 7;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 5;

  localparam int          SIG_W     = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  // Cycles between presenting a vector and the matching response on b_in.
  localparam int DUT_LAT = 2;

  // An all-zero seed would lock the LFSR at zero forever.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? LFSR_W'(1) : s;
  endfunction

endpackage

// File: rtl/lfsr7.sv
// ---------------------------------------------------------------------------
// lfsr7
//   7-bit Fibonacci LFSR, polynomial x^7 + x^6 + 1 (maximal length 127).
//   next = {q[5:0], q[6] ^ q[5]}
//
// Ports
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, loads seed
//   load   : load seed (priority over enable)
//   enable : advance one step
//   seed   : start value (caller guarantees non-zero)
//   q      : current LFSR value
// ---------------------------------------------------------------------------
module lfsr7
  import stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic feedback;

  assign feedback = q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO];

  always_ff @(posedge clk) begin
    if (rst || load) begin
      q <= seed;
    end else if (enable) begin
      q <= {q[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/stim_sequencer.sv
// ---------------------------------------------------------------------------
// stim_sequencer
//   Applies num_pat pseudo-random 7-bit vectors to a downstream stage and
//   compacts the returned 1-bit responses into a 16-bit MISR signature.
//   Responses arrive DUT_LAT cycles after their vector; a valid shift
//   register tracks which b_in samples belong to a live vector, and a DRAIN
//   phase waits for the last responses before reporting DONE.
//
// Parameters
//   SEED  : LFSR start value (0 is replaced by 7'h01)
//   CNT_W : width of the pattern counter / num_pat
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (priority over start)
//   start   : one-cycle run request, accepted in IDLE or DONE only
//   num_pat : number of patterns, sampled with start
//   a       : stimulus vector, 0 outside RUN
//   a_valid : a carries a live pattern
//   b_in    : response from the downstream stage
//   busy    : high in RUN and DRAIN
//   done    : level, high in DONE
//   sig     : MISR signature of captured responses
// ---------------------------------------------------------------------------
module stim_sequencer
  import stim_pkg::*;
#(
  parameter logic [6:0] SEED  = 7'h01,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pat,
  output logic [6:0]       a,
  output logic             a_valid,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sig
);

  localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

  localparam int                 DRAIN_W    = (DUT_LAT > 2) ? $clog2(DUT_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DUT_LAT - 1);

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic             bit_in);
    logic [SIG_W-1:0] shifted;
    shifted = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0);
    return shifted ^ {{(SIG_W-1){1'b0}}, bit_in};
  endfunction

  state_t              state_q;
  state_t              state_d;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [SIG_W-1:0]    sig_q;

  logic                lfsr_load;
  logic                lfsr_en;
  logic                load_run;
  logic                clr_sig;
  logic                enter_drain;

  // Valid pipe: vld_p1 marks a vector presented last cycle, vld_p2 marks the
  // cycle whose b_in is that vector's response.
  logic                vld_p1;
  logic                vld_p2;

  lfsr7 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .enable (lfsr_en),
    .seed   (SEED_EFF),
    .q      (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a           = '0;
    a_valid     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    load_run    = 1'b0;
    clr_sig     = 1'b0;
    enter_drain = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          clr_sig = 1'b1;
          if (num_pat != '0) begin
            lfsr_load = 1'b1;
            load_run  = 1'b1;
            state_d   = ST_RUN;
          end else begin
            state_d   = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        a       = lfsr_q;
        a_valid = 1'b1;
        busy    = 1'b1;
        lfsr_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          enter_drain = 1'b1;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- stage p1/p2: response alignment, counters and signature ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      drain_q <= '0;
      sig_q   <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      vld_p1 <= a_valid;
      vld_p2 <= vld_p1;

      if (load_run) begin
        cnt_q <= num_pat;
      end else if (a_valid) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (enter_drain) begin
        drain_q <= DRAIN_LAST;
      end else if (state_q == ST_DRAIN && drain_q != '0) begin
        drain_q <= drain_q - DRAIN_W'(1);
      end

      if (clr_sig) begin
        sig_q <= '0;
      end else if (vld_p2) begin
        sig_q <= misr_step(sig_q, b_in);
      end
    end
  end

  assign sig = sig_q;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

  localparam logic [6:0] SEED  = 7'h01;
  localparam int         CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_pat;
  logic [6:0]       a;
  logic             a_valid;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [15:0]      sig;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  stim_sequencer #(.SEED(SEED), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .num_pat (num_pat),
    .a       (a),
    .a_valid (a_valid),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .sig     (sig)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A run is described by the cycle index k since the accepted start:
  // vectors are shown for k < n, responses are folded in for 2 <= k <= n+1,
  // and the run reports done once k passes n+1.
  typedef struct packed {
    logic        active;
    logic        fin;
    int          k;
    int          n;
    logic [6:0]  lf;
    logic [15:0] sg;
  } mdl_t;

  mdl_t m;

  function automatic logic [6:0] lfsr_next(input logic [6:0] v);
    return {v[5:0], v[6] ^ v[5]};
  endfunction

  function automatic logic [15:0] misr(input logic [15:0] s, input logic b);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {15'b0, b};
  endfunction

  function automatic mdl_t mstep(input mdl_t cur, input logic r, input logic s,
                                 input int np, input logic b);
    mdl_t nx;
    nx = cur;
    if (r) begin
      nx = '{active: 1'b0, fin: 1'b0, k: 0, n: 0, lf: SEED, sg: 16'h0};
    end else if (cur.active) begin
      if (cur.k >= 2 && cur.k <= cur.n + 1) nx.sg = misr(cur.sg, b);
      if (cur.k < cur.n) nx.lf = lfsr_next(cur.lf);
      nx.k = cur.k + 1;
      if (cur.k == cur.n + 1) begin
        nx.active = 1'b0;
        nx.fin    = 1'b1;
      end
    end else if (s) begin
      nx.sg = 16'h0;
      if (np != 0) begin
        nx.active = 1'b1;
        nx.fin    = 1'b0;
        nx.k      = 0;
        nx.n      = np;
        nx.lf     = SEED;
      end else begin
        nx.fin = 1'b1;
      end
    end
    return nx;
  endfunction

  always @(posedge clk) m <= mstep(m, rst, start, int'(num_pat), b_in);

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_a",       {25'b0, a},  {25'b0, (m.active && m.k < m.n) ? m.lf : 7'h00});
      chk("m_a_valid", {31'b0, a_valid}, {31'b0, m.active && (m.k < m.n)});
      chk("m_busy",    {31'b0, busy},    {31'b0, m.active});
      chk("m_done",    {31'b0, done},    {31'b0, m.fin});
      chk("m_sig",     {16'b0, sig},     {16'b0, m.sg});
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int np);
    @(negedge clk);
    start   = 1'b1;
    num_pat = CNT_W'(np);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("wait_done", {31'b0, done}, 32'd1);
  endtask

  logic [6:0] pats[$];
  logic [6:0] first7 [7];
  bit         seen [128];
  int         ndup;
  int         nv;

  initial begin
    first7 = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};
    rst = 1; start = 0; num_pat = '0; b_in = 0;

    // reset
    repeat (2) @(negedge clk);
    cmp_en = 1;
    chk("rst_a",       {25'b0, a}, 32'h0);
    chk("rst_a_valid", {31'b0, a_valid}, 32'h0);
    chk("rst_busy",    {31'b0, busy}, 32'h0);
    chk("rst_done",    {31'b0, done}, 32'h0);
    chk("rst_sig",     {16'b0, sig}, 32'h0);
    rst = 0;

    // single pattern, response 1
    b_in = 1;
    pulse_start(1);
    chk("n1_a",    {25'b0, a}, 32'h01);
    chk("n1_busy0", {31'b0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("n1_busy2", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("n1_done", {31'b0, done}, 32'd1);
    chk("n1_busy3", {31'b0, busy}, 32'd0);
    chk("n1_sig",  {16'b0, sig}, 32'h0001);

    // full period, responses 0
    b_in = 0;
    pulse_start(127);
    pats.delete();
    for (int i = 0; i < 400 && !done; i++) begin
      if (a_valid) pats.push_back(a);
      @(negedge clk);
    end
    chk("n127_done",  {31'b0, done}, 32'd1);
    chk("n127_count", pats.size(), 32'd127);
    for (int i = 0; i < 7 && i < pats.size(); i++)
      chk("n127_first", {25'b0, pats[i]}, {25'b0, first7[i]});
    foreach (seen[i]) seen[i] = 0;
    ndup = 0;
    foreach (pats[i]) begin
      if (seen[pats[i]]) ndup++;
      seen[pats[i]] = 1;
    end
    chk("n127_dups", ndup, 32'd0);
    chk("n127_zero", {31'b0, seen[0]}, 32'd0);
    chk("n127_lfsr", {25'b0, dut.u_lfsr.q}, 32'h01);
    chk("n127_sig",  {16'b0, sig}, 32'h0);

    // three ones -> signature 7, then num_pat=0 clears it
    b_in = 1;
    pulse_start(3);
    wait_done(20);
    chk("n3_sig", {16'b0, sig}, 32'h0007);
    pulse_start(0);
    chk("n0_done_from_done", {31'b0, done}, 32'd1);
    chk("n0_sig", {16'b0, sig}, 32'h0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("n0_pre_done", {31'b0, done}, 32'd0);
    pulse_start(0);
    chk("n0_done",    {31'b0, done}, 32'd1);
    chk("n0_a_valid", {31'b0, a_valid}, 32'd0);
    chk("n0_busy",    {31'b0, busy}, 32'd0);

    // start during RUN is ignored
    pulse_start(10);
    nv = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (a_valid) nv++;
      if (i == 3) begin start = 1; num_pat = 8'd5; end
      else start = 0;
      @(negedge clk);
    end
    start = 0;
    chk("n10_count", nv, 32'd10);
    pulse_start(4);
    chk("restart_a", {25'b0, a}, 32'h01);
    wait_done(20);

    // reset on the third RUN cycle
    pulse_start(10);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_a",    {25'b0, a}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    b_in = 1;
    pulse_start(2);
    chk("after_abort_a", {25'b0, a}, 32'h01);
    wait_done(20);
    chk("n2_sig", {16'b0, sig}, 32'h0003);

    // random responses, signature checked by the model
    pulse_start(20);
    for (int i = 0; i < 100 && !done; i++) begin
      b_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    chk("rand_done", {31'b0, done}, 32'd1);

    // maximum count wraps the sequence
    b_in = 0;
    pulse_start(255);
    pats.delete();
    for (int i = 0; i < 600 && !done; i++) begin
      if (a_valid) pats.push_back(a);
      @(negedge clk);
    end
    chk("n255_done",  {31'b0, done}, 32'd1);
    chk("n255_count", pats.size(), 32'd255);
    if (pats.size() > 128) begin
      chk("n255_wrap0", {25'b0, pats[127]}, 32'h01);
      chk("n255_wrap1", {25'b0, pats[128]}, 32'h02);
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 The block SHALL have parameter SEED, default 7'h01, the LFSR start value; a value of 0 SHALL be replaced by 7'h01.
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the pattern counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
REQ-006 The block SHALL have port num_pat, input, CNT_W bits: the number of patterns to apply, sampled on start.
REQ-007 The block SHALL have port a, output, 7 bits: the stimulus vector driving the downstream stage's a[6:0].
REQ-008 The block SHALL have port a_valid, output, 1 bit: high when a carries a live pattern.
REQ-009 The block SHALL have port b_in, input, 1 bit: the response returned from the downstream stage's b.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN and DRAIN.
REQ-011 The block SHALL have port done, output, 1 bit: a level, high in DONE.
REQ-012 The block SHALL have port sig, output, 16 bits: the MISR signature of the captured b_in values.

Function
REQ-013 The FSM SHALL have four states: IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE and DONE, start with num_pat != 0 SHALL load lfsr=SEED, cnt=num_pat and sig=0, and go to RUN next cycle.
REQ-015 In IDLE and DONE, start with num_pat == 0 SHALL clear sig and go to DONE next cycle.
REQ-016 In RUN, each cycle SHALL output a=lfsr with a_valid=1, advance lfsr and decrement cnt; when cnt==1 the FSM SHALL go to DRAIN.
REQ-017 The LFSR SHALL be x^7+x^6+1: next = {lfsr[5:0], lfsr[6]^lfsr[5]}, maximal length 127, never reaching 0.
REQ-018 Outside RUN, a SHALL be 7'h00 and a_valid SHALL be 0.
REQ-019 DRAIN SHALL last exactly DUT_LAT=2 cycles and then go to DONE.
REQ-020 Each b_in sample SHALL be captured exactly DUT_LAT cycles after its a_valid cycle, tracked by a 2-deep valid shift register.
REQ-021 On each capture, sig SHALL update as sig_next = ({sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000)) ^ {15'b0, b_in}.
REQ-022 Captures SHALL number exactly num_pat per run; the last capture SHALL occur in the final DRAIN cycle.
REQ-023 start in RUN or DRAIN SHALL be ignored.
REQ-024 sig SHALL hold its value in DONE until the next accepted start.
REQ-025 num_pat = 2^CNT_W-1 SHALL be legal; above 127 the pattern sequence SHALL wrap and repeat.

Reset
REQ-026 rst SHALL force state=IDLE, a=0, a_valid=0, busy=0, done=0, sig=0, lfsr=SEED, cnt=0 and clear the valid pipe on the next clk edge.
REQ-027 rst during RUN or DRAIN SHALL abort the run with no further captures; rst SHALL take priority over start.

Structure
REQ-028 Package stim_pkg SHALL hold the state enum, LFSR taps, MISR polynomial 16'h1021 and DUT_LAT=2.
REQ-029 The LFSR SHALL be the sub-module lfsr7 (load, enable, seed); the FSM, counter and MISR SHALL be inline.

Verification
REQ-030 rst for 2 cycles -> a=0, a_valid=0, busy=0, done=0, sig=16'h0000.
REQ-031 start, num_pat=1, b_in=1 -> a=7'h01 for 1 cycle, busy for 3 cycles, then done=1 and sig=16'h0001.
REQ-032 start, num_pat=127, b_in=0 -> 127 distinct nonzero vectors starting 01,02,04,08,10,20,41; internal lfsr returns to 7'h01; sig=0.
REQ-033 start, num_pat=0 -> done=1 on the next cycle, a_valid never asserted, sig=0.
REQ-034 start during RUN (num_pat=10) -> exactly 10 patterns; a second start in DONE restarts with a=7'h01.
REQ-035 rst asserted on the 3rd RUN cycle -> IDLE next cycle, a=0; a later start runs normally.
